// File: rtl/dmb_fifo_rdport.sv
// dmb_fifo_rdport: single-channel event FIFO behind the DMB control block's
// FIFO read interface. Words from a front-end writer are buffered in a dual-port
// RAM with registered read. A first-word-fall-through output register sits after
// the RAM, and the block keeps a count of complete events so the controller can
// wait for a whole event before it starts reading.
//
// Pipeline: RAM storage -> ram_q (registered RAM read) -> DATAOUT (head word).
// All three stages count toward WRCNT and toward the 2^DEPTH_LOG2 capacity.

module dmb_fifo_rdport #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 18
) (
    input  logic                  CLKDDU,
    input  logic                  RST_B,
    input  logic                  FIFOMRST,
    input  logic                  WE,
    input  logic [WIDTH-1:0]      WDATA,
    input  logic                  RENFIFO_B,
    input  logic                  OEFIFO_B,
    output logic [WIDTH-1:0]      DATAOUT,
    output logic                  DOE,
    output logic                  FFOR_B,
    output logic                  FULL,
    output logic                  EVT_AV,
    output logic [DEPTH_LOG2:0]   EVTCNT,
    output logic [DEPTH_LOG2:0]   WRCNT,
    output logic                  OVF,
    output logic                  UNF
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    // Storage and pipeline state
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   mem_cnt;
    logic [WIDTH-1:0]      ram_q;
    logic                  ram_q_valid;
    logic                  out_valid;

    // Per-cycle decisions
    logic                  wr_acc;
    logic                  pop;
    logic                  out_load;
    logic                  ram_rd;
    logic                  evt_inc;
    logic                  evt_dec;
    logic [DEPTH_LOG2:0]   evtcnt_nxt;

    assign FULL   = (WRCNT == CNT_FULL);
    assign FFOR_B = ~out_valid;
    assign DOE    = ~OEFIFO_B;

    // Handshake decisions. ram_q refills in the same cycle that it hands its
    // word to the output register, which keeps back-to-back pops free of bubbles.
    // A RAM read only targets words written on an earlier edge, so a read never
    // collides with a write to the same address.
    always_comb begin
        wr_acc     = WE & ~FULL;
        pop        = ~RENFIFO_B & out_valid;
        out_load   = ram_q_valid & (~out_valid | pop);
        ram_rd     = (mem_cnt != '0) & (~ram_q_valid | out_load);
        evt_inc    = wr_acc & WDATA[WIDTH-1];
        evt_dec    = pop & DATAOUT[WIDTH-1];
        evtcnt_nxt = EVTCNT;
        if (evt_inc && !evt_dec) begin
            evtcnt_nxt = EVTCNT + CNT_ONE;
        end else if (!evt_inc && evt_dec) begin
            evtcnt_nxt = EVTCNT - CNT_ONE;
        end
    end

    // RAM write port; the data array carries no reset because contents are
    // qualified by the pointers and counts.
    always_ff @(posedge CLKDDU) begin
        if (wr_acc) begin
            mem[wr_ptr] <= WDATA;
        end
    end

    // Registered RAM read into the prefetch stage.
    always_ff @(posedge CLKDDU) begin
        if (ram_rd) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Pointers and the count of words still held inside the RAM.
    always_ff @(posedge CLKDDU or negedge RST_B) begin
        if (!RST_B) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else if (FIFOMRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_acc && !ram_rd) begin
                mem_cnt <= mem_cnt + CNT_ONE;
            end else if (!wr_acc && ram_rd) begin
                mem_cnt <= mem_cnt - CNT_ONE;
            end
        end
    end

    // Prefetch and output-register occupancy plus the head word itself.
    always_ff @(posedge CLKDDU or negedge RST_B) begin
        if (!RST_B) begin
            ram_q_valid <= 1'b0;
            out_valid   <= 1'b0;
            DATAOUT     <= '0;
        end else if (FIFOMRST) begin
            ram_q_valid <= 1'b0;
            out_valid   <= 1'b0;
            DATAOUT     <= '0;
        end else begin
            if (ram_rd) begin
                ram_q_valid <= 1'b1;
            end else if (out_load) begin
                ram_q_valid <= 1'b0;
            end
            if (out_load) begin
                out_valid <= 1'b1;
                DATAOUT   <= ram_q;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Total stored words. This count also defines FULL, so a write while full
    // is dropped even if a pop happens in the same cycle.
    always_ff @(posedge CLKDDU or negedge RST_B) begin
        if (!RST_B) begin
            WRCNT <= '0;
        end else if (FIFOMRST) begin
            WRCNT <= '0;
        end else if (wr_acc && !pop) begin
            WRCNT <= WRCNT + CNT_ONE;
        end else if (!wr_acc && pop) begin
            WRCNT <= WRCNT - CNT_ONE;
        end
    end

    // Complete-event count and its registered non-zero flag.
    always_ff @(posedge CLKDDU or negedge RST_B) begin
        if (!RST_B) begin
            EVTCNT <= '0;
            EVT_AV <= 1'b0;
        end else if (FIFOMRST) begin
            EVTCNT <= '0;
            EVT_AV <= 1'b0;
        end else begin
            EVTCNT <= evtcnt_nxt;
            EVT_AV <= (evtcnt_nxt != '0);
        end
    end

    // Sticky error flags for writes into a full FIFO and pops with no head word.
    always_ff @(posedge CLKDDU or negedge RST_B) begin
        if (!RST_B) begin
            OVF <= 1'b0;
            UNF <= 1'b0;
        end else if (FIFOMRST) begin
            OVF <= 1'b0;
            UNF <= 1'b0;
        end else begin
            if (WE && FULL) begin
                OVF <= 1'b1;
            end
            if (!RENFIFO_B && !out_valid) begin
                UNF <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmb_fifo_rdport.sv
// tb_dmb_fifo_rdport: self-checking bench for dmb_fifo_rdport. The reference
// model is a queue of stored words, each tagged with the edge that wrote it.
// A word is the visible head once two edges have passed since its write.

module tb_dmb_fifo_rdport;

    localparam int DL    = 9;
    localparam int W     = 18;
    localparam int DEPTH = 512;

    logic          CLKDDU;
    logic          rst_b;
    logic          mrst;
    logic          we;
    logic [W-1:0]  wdata;
    logic          ren_b;
    logic          oe_b;
    logic [W-1:0]  DATAOUT;
    logic          DOE;
    logic          FFOR_B;
    logic          FULL;
    logic          EVT_AV;
    logic [DL:0]   EVTCNT;
    logic [DL:0]   WRCNT;
    logic          OVF;
    logic          UNF;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0]  m_data[$];
    int            m_wedge[$];
    int            m_edge = 0;
    bit            m_ovf;
    bit            m_unf;
    logic [W-1:0]  m_shown;

    typedef struct {
        bit          we;
        logic [W-1:0] wd;
        bit          ren_b;
        bit          mrst;
        bit          e_ffor;
        logic [W-1:0] e_dout;
        int          e_wrcnt;
        int          e_evt;
        bit          e_unf;
    } vec_t;

    vec_t vecs[9];

    dmb_fifo_rdport #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .CLKDDU    (CLKDDU),
        .RST_B     (rst_b),
        .FIFOMRST  (mrst),
        .WE        (we),
        .WDATA     (wdata),
        .RENFIFO_B (ren_b),
        .OEFIFO_B  (oe_b),
        .DATAOUT   (DATAOUT),
        .DOE       (DOE),
        .FFOR_B    (FFOR_B),
        .FULL      (FULL),
        .EVT_AV    (EVT_AV),
        .EVTCNT    (EVTCNT),
        .WRCNT     (WRCNT),
        .OVF       (OVF),
        .UNF       (UNF)
    );

    initial CLKDDU = 1'b0;
    always #5 CLKDDU = ~CLKDDU;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit mVisible();
        return (m_data.size() > 0) && (m_edge >= m_wedge[0] + 2);
    endfunction

    function automatic int mEvtCnt();
        int n = 0;
        foreach (m_data[i]) if (m_data[i][W-1]) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] fillWord(input int i);
        logic [W-1:0] v;
        v = {((i % 64) == 63), 17'(i * 3 + 5)};
        return v;
    endfunction

    task automatic modelReset();
        m_data.delete();
        m_wedge.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_shown = '0;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic modelEdge();
        bit vis;
        bit full;
        vis  = mVisible();
        full = (m_data.size() == DEPTH);
        m_edge++;
        if (!rst_b || mrst) begin
            modelReset();
            return;
        end
        if (we && full) m_ovf = 1'b1;
        if (!ren_b && !vis) m_unf = 1'b1;
        if (!ren_b && vis) begin
            void'(m_data.pop_front());
            void'(m_wedge.pop_front());
        end
        if (we && !full) begin
            m_data.push_back(wdata);
            m_wedge.push_back(m_edge);
        end
        if (mVisible()) m_shown = m_data[0];
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int n;
        n = mEvtCnt();
        cmp("ffor_b",  FFOR_B,  !mVisible());
        cmp("dataout", DATAOUT, m_shown);
        cmp("wrcnt",   WRCNT,   m_data.size());
        cmp("evtcnt",  EVTCNT,  n);
        cmp("evt_av",  EVT_AV,  n != 0);
        cmp("full",    FULL,    m_data.size() == DEPTH);
        cmp("ovf",     OVF,     m_ovf);
        cmp("unf",     UNF,     m_unf);
        cmp("doe",     DOE,     !oe_b);
    endtask

    task automatic applyStimulus(input bit we_i, input logic [W-1:0] wd_i,
                                 input bit ren_i, input bit mrst_i);
        we    = we_i;
        wdata = wd_i;
        ren_b = ren_i;
        mrst  = mrst_i;
    endtask

    task automatic stepCycle();
        @(posedge CLKDDU);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        rst_b = 1'b0;
        oe_b  = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        modelReset();

        // Reset state
        repeat (3) stepCycle();
        @(negedge CLKDDU);
        rst_b = 1'b1;
        stepCycle();
        cmp("reset_ffor", FFOR_B, 1'b1);
        cmp("reset_wrcnt", WRCNT, 0);

        // Hand-written vectors: three-word event, drain, pop on empty, clear
        vecs[0] = '{1'b1, 18'h00001, 1'b1, 1'b0, 1'b1, 18'h00000, 1, 0, 1'b0};
        vecs[1] = '{1'b1, 18'h00002, 1'b1, 1'b0, 1'b1, 18'h00000, 2, 0, 1'b0};
        vecs[2] = '{1'b1, 18'h20003, 1'b1, 1'b0, 1'b0, 18'h00001, 3, 1, 1'b0};
        vecs[3] = '{1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 18'h00001, 3, 1, 1'b0};
        vecs[4] = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 18'h00002, 2, 1, 1'b0};
        vecs[5] = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 18'h20003, 1, 1, 1'b0};
        vecs[6] = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b1, 18'h20003, 0, 0, 1'b0};
        vecs[7] = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b1, 18'h20003, 0, 0, 1'b1};
        vecs[8] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h00000, 0, 0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].ren_b, vecs[i].mrst);
            stepCycle();
            cmp("tbl_ffor",   FFOR_B,  vecs[i].e_ffor);
            cmp("tbl_dout",   DATAOUT, vecs[i].e_dout);
            cmp("tbl_wrcnt",  WRCNT,   vecs[i].e_wrcnt);
            cmp("tbl_evtcnt", EVTCNT,  vecs[i].e_evt);
            cmp("tbl_evtav",  EVT_AV,  vecs[i].e_evt != 0);
            cmp("tbl_unf",    UNF,     vecs[i].e_unf);
        end

        // Fill to capacity, overflow, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, fillWord(i), 1'b1, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (2) stepCycle();
        cmp("fill_full", FULL, 1'b1);
        cmp("fill_evtcnt", EVTCNT, 8);
        cmp("fill_wrcnt", WRCNT, DEPTH);
        applyStimulus(1'b1, 18'h3ffff, 1'b1, 1'b0);
        stepCycle();
        cmp("ovf_set", OVF, 1'b1);
        cmp("ovf_wrcnt", WRCNT, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            cmp("drain_ffor", FFOR_B, 1'b0);
            cmp("drain_data", DATAOUT, fillWord(i));
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            stepCycle();
        end
        cmp("drain_evtcnt", EVTCNT, 0);
        cmp("drain_wrcnt", WRCNT, 0);
        cmp("drain_ffor_end", FFOR_B, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        stepCycle();
        cmp("mrst_ovf", OVF, 1'b0);

        // Half full, then sustained simultaneous write and pop with wrap
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, {((k % 37) == 0), 17'(k)}, 1'b1, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (3) stepCycle();
        for (int k = 0; k < 1000; k++) begin
            cmp("stream_ffor", FFOR_B, 1'b0);
            cmp("stream_data", DATAOUT, {((k % 37) == 0), 17'(k)});
            applyStimulus(1'b1, {(((k + 256) % 37) == 0), 17'(k + 256)}, 1'b0, 1'b0);
            stepCycle();
            cmp("stream_wrcnt", WRCNT, 256);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        stepCycle();

        // Randomized traffic in phases with different write/pop pressure
        for (int ph = 0; ph < 4; ph++) begin
            int wp;
            int rp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 60 : 95;
            rp = (ph == 0) ? 30 : (ph == 1) ? 85 : (ph == 2) ? 60 : 15;
            for (int c = 0; c < 700; c++) begin
                applyStimulus($urandom_range(0, 99) < wp, W'($urandom),
                              !($urandom_range(0, 99) < rp),
                              $urandom_range(0, 999) < 3);
                stepCycle();
            end
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        stepCycle();

        // Underflow on empty, OE toggling, then asynchronous reset mid-stream
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        stepCycle();
        cmp("unf_set", UNF, 1'b1);
        cmp("unf_dout", DATAOUT, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 18'h10 + 18'(k), 1'b1, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (3) stepCycle();
        for (int k = 0; k < 6; k++) begin
            bit oe_bit;
            oe_bit = k[0];
            oe_b = oe_bit;
            #1;
            cmp("doe_same_cycle", DOE, !oe_bit);
            stepCycle();
            cmp("oe_wrcnt", WRCNT, 5);
            cmp("oe_dout", DATAOUT, 18'h10);
        end
        oe_b = 1'b1;
        @(posedge CLKDDU);
        modelEdge();
        #3;
        rst_b = 1'b0;
        modelReset();
        #1;
        cmp("async_ffor", FFOR_B, 1'b1);
        cmp("async_dout", DATAOUT, 0);
        cmp("async_wrcnt", WRCNT, 0);
        cmp("async_evtav", EVT_AV, 1'b0);
        cmp("async_unf", UNF, 1'b0);
        checkOutput();
        repeat (2) stepCycle();
        @(negedge CLKDDU);
        rst_b = 1'b1;
        repeat (3) stepCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
